multicycle_control: RTL and testbench

// - Multi-cycle successor to the single-cycle CPU control path: FSM sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
// - Decodes add addi addu sub subu and or sll slt sltu lw sw beq bne bgtz and drives datapath strobes.
// - Sits between the instruction register (op/funct held stable after FETCH) and shared-memory/regfile/ALU datapath.
// - Adds a memory ready handshake with timeout, an illegal-opcode path and an optional overflow trap.

---
 rtl/cpu_ctrl_pkg.sv | 76 +++++++
 rtl/mc_alu_decode.sv | 46 ++++
 rtl/multicycle_control.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU control path:
// FSM states, opcode/funct values, ALU control codes and the strobe bundle.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_ADDU = 3'd4;
  localparam logic [2:0] ALU_SLL  = 3'd5;
  localparam logic [2:0] ALU_SUB  = 3'd6;
  localparam logic [2:0] ALU_SLTU = 3'd7;

  localparam logic [1:0] SRCB_BUSB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [2:0] {
    IC_RTYPE  = 3'd0,
    IC_ADDI   = 3'd1,
    IC_LW     = 3'd2,
    IC_SW     = 3'd3,
    IC_BEQ    = 3'd4,
    IC_BNE    = 3'd5,
    IC_BGTZ   = 3'd6,
    IC_NONE   = 3'd7
  } iclass_t;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       ir_wr;
    logic       pc_wr;
    logic       pc_src;
    logic       reg_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       ext_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctr;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;
    logic       trap;
  } ctrl_t;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational op/funct decode: ALU operation for EXEC, instruction class,
// legality, and whether the instruction is a signed op that may trap.
module mc_alu_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctr,
  output iclass_t    iclass,
  output logic       legal,
  output logic       ovf_chk
);

  always_comb begin
    alu_ctr = ALU_ADD;
    iclass  = IC_NONE;
    legal   = 1'b1;
    ovf_chk = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        iclass = IC_RTYPE;
        unique case (funct)
          FN_SLL:  alu_ctr = ALU_SLL;
          FN_ADD:  begin alu_ctr = ALU_ADD; ovf_chk = 1'b1; end
          FN_ADDU: alu_ctr = ALU_ADDU;
          FN_SUB:  begin alu_ctr = ALU_SUB; ovf_chk = 1'b1; end
          // subu shares the subtractor; only the trap check differs
          FN_SUBU: alu_ctr = ALU_SUB;
          FN_AND:  alu_ctr = ALU_AND;
          FN_OR:   alu_ctr = ALU_OR;
          FN_SLT:  alu_ctr = ALU_SLT;
          FN_SLTU: alu_ctr = ALU_SLTU;
          default: begin legal = 1'b0; iclass = IC_NONE; end
        endcase
      end
      OP_ADDI: begin iclass = IC_ADDI; ovf_chk = 1'b1; end
      OP_LW:   iclass = IC_LW;
      OP_SW:   iclass = IC_SW;
      OP_BEQ:  begin iclass = IC_BEQ;  alu_ctr = ALU_SUB; end
      OP_BNE:  begin iclass = IC_BNE;  alu_ctr = ALU_SUB; end
      OP_BGTZ: begin iclass = IC_BGTZ; alu_ctr = ALU_SUB; end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB) with mem_ready timeout
// and illegal-opcode path. Define CPU_OVF_TRAP_EN to enable the signed-overflow trap.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       equal,
  input  logic       sign,
  input  logic       ovf,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic       pc_src,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       ext_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctr,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err,
  output logic       trap,
  output logic [2:0] dbg_state
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

  state_t          state, next_state;
  logic [TO_W-1:0] to_cnt, next_cnt;
  ctrl_t           ctrl, ctrl_out;

  logic [2:0] dec_alu_ctr;
  iclass_t    dec_iclass;
  logic       dec_legal;
  logic       dec_ovf_chk;
  logic       waiting;
  logic       timed_out;
  logic       taken;

  mc_alu_decode u_dec (
    .op      (op),
    .funct   (funct),
    .alu_ctr (dec_alu_ctr),
    .iclass  (dec_iclass),
    .legal   (dec_legal),
    .ovf_chk (dec_ovf_chk)
  );

  // mem_ready only counts while a request is outstanding (FETCH or MEM).
  assign waiting   = ((state == FETCH) || (state == MEM)) && !mem_ready;
  assign timed_out = waiting && (MEM_TIMEOUT != 0) && (to_cnt == TO_LIM);
  assign next_cnt  = (waiting && !timed_out && (MEM_TIMEOUT != 0)) ? to_cnt + 1'b1 : '0;

  always_comb begin
    taken = 1'b0;
    unique case (dec_iclass)
      IC_BEQ:  taken = equal;
      IC_BNE:  taken = !equal;
      IC_BGTZ: taken = !equal && !sign;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    ctrl       = '0;
    next_state = state;
    unique case (state)
      FETCH: begin
        if (timed_out) begin
          ctrl.bus_err = 1'b1;
        end else begin
          ctrl.mem_rd = 1'b1;
          if (mem_ready) begin
            ctrl.ir_wr     = 1'b1;
            ctrl.pc_wr     = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_ctr   = ALU_ADDU;
            next_state     = DECODE;
          end
        end
      end
      DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_ctr   = ALU_ADDU;
        if (!dec_legal) begin
          ctrl.illegal = 1'b1;
          next_state   = FETCH;
        end else begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        unique case (dec_iclass)
          IC_RTYPE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_BUSB;
            ctrl.alu_ctr   = dec_alu_ctr;
            next_state     = WB;
          end
          IC_ADDI, IC_LW, IC_SW: begin
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.ext_op    = 1'b1;
            ctrl.alu_ctr   = ALU_ADD;
            next_state     = (dec_iclass == IC_ADDI) ? WB : MEM;
          end
          default: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_BUSB;
            ctrl.alu_ctr    = ALU_SUB;
            ctrl.pc_wr      = taken;
            ctrl.pc_src     = taken;
            ctrl.instr_done = 1'b1;
            next_state      = FETCH;
          end
        endcase
`ifdef CPU_OVF_TRAP_EN
        if (dec_ovf_chk && ovf) begin
          ctrl.trap  = 1'b1;
          next_state = FETCH;
        end
`endif
      end
      MEM: begin
        if (timed_out) begin
          ctrl.bus_err = 1'b1;
          next_state   = FETCH;
        end else begin
          ctrl.iord   = 1'b1;
          ctrl.mem_rd = (dec_iclass == IC_LW);
          ctrl.mem_wr = (dec_iclass == IC_SW);
          if (mem_ready) begin
            if (dec_iclass == IC_LW) begin
              next_state = WB;
            end else begin
              ctrl.instr_done = 1'b1;
              next_state      = FETCH;
            end
          end
        end
      end
      WB: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.reg_dst    = (dec_iclass == IC_RTYPE);
        ctrl.mem_to_reg = (dec_iclass == IC_LW);
        ctrl.instr_done = 1'b1;
        next_state      = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

`ifndef CPU_OVF_TRAP_EN
  logic ovf_unused;
  assign ovf_unused = ovf ^ dec_ovf_chk;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      to_cnt <= '0;
    end else begin
      state  <= next_state;
      to_cnt <= next_cnt;
    end
  end

  // Reset gates every strobe immediately so an abort never leaks a write.
  assign ctrl_out   = rst ? '0 : ctrl;
  assign mem_rd     = ctrl_out.mem_rd;
  assign mem_wr     = ctrl_out.mem_wr;
  assign iord       = ctrl_out.iord;
  assign ir_wr      = ctrl_out.ir_wr;
  assign pc_wr      = ctrl_out.pc_wr;
  assign pc_src     = ctrl_out.pc_src;
  assign reg_wr     = ctrl_out.reg_wr;
  assign reg_dst    = ctrl_out.reg_dst;
  assign mem_to_reg = ctrl_out.mem_to_reg;
  assign ext_op     = ctrl_out.ext_op;
  assign alu_src_a  = ctrl_out.alu_src_a;
  assign alu_src_b  = ctrl_out.alu_src_b;
  assign alu_ctr    = ctrl_out.alu_ctr;
  assign instr_done = ctrl_out.instr_done;
  assign illegal    = ctrl_out.illegal;
  assign bus_err    = ctrl_out.bus_err;
  assign trap       = ctrl_out.trap;
  assign dbg_state  = rst ? 3'd0 : state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control (MEM_TIMEOUT=4): driver pushes
// hand-computed per-cycle output vectors, a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam int W = 23;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       equal, sign, ovf, mem_ready;
  logic       mem_rd, mem_wr, iord, ir_wr, pc_wr, pc_src, reg_wr, reg_dst;
  logic       mem_to_reg, ext_op, alu_src_a, instr_done, illegal, bus_err, trap;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctr, dbg_state;

  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;

  logic [W-1:0] zero_v, f_wait, f_go, dec_v, dec_ill, wb_r, wb_i, ex_mi;
  logic [W-1:0] mem_lw, wb_lw, mem_sw, br_tk, br_nt, berr_f, berr_m;

  multicycle_control #(.MEM_TIMEOUT(4), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .equal(equal), .sign(sign),
    .ovf(ovf), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .iord(iord), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .ext_op(ext_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctr(alu_ctr), .instr_done(instr_done), .illegal(illegal),
    .bus_err(bus_err), .trap(trap), .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ev(
    input logic [2:0] st, input logic mrd, mwr, io, irw, pcw, pcs, rw, rd, m2r,
    ext, asa, input logic [1:0] asb, input logic [2:0] actr,
    input logic done, ill, be, tr);
    return {st, mrd, mwr, io, irw, pcw, pcs, rw, rd, m2r, ext, asa, asb, actr,
            done, ill, be, tr};
  endfunction

  function automatic logic [W-1:0] ex_r(input logic [2:0] actr);
    return ev(3'd2, 0,0,0,0,0,0,0,0,0,0,1, 2'b00, actr, 0,0,0,0);
  endfunction

  // driver: one call = one clock cycle of inputs plus its expected outputs
  task automatic step(input logic r, input logic [5:0] o, f,
                      input logic eq, sg, ov, rdy, input logic [W-1:0] e);
    rst = r; op = o; funct = f; equal = eq; sign = sg; ovf = ov; mem_ready = rdy;
    exp_q.push_back(e);
    id_q.push_back(cyc);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [5:0] o, f);
    step(0, o, f, 0, 0, 0, 1, f_go);
    step(0, o, f, 0, 0, 0, 1, dec_v);
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] act, e;
    int id;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        act = {dbg_state, mem_rd, mem_wr, iord, ir_wr, pc_wr, pc_src, reg_wr,
               reg_dst, mem_to_reg, ext_op, alu_src_a, alu_src_b, alu_ctr,
               instr_done, illegal, bus_err, trap};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL cycle_%0d: got %b expected %b", id, act, e);
        end
      end
    end
  end

  initial begin
    zero_v  = '0;
    f_wait  = ev(3'd0, 1,0,0,0,0,0,0,0,0,0,0, 2'b00, 3'd0, 0,0,0,0);
    f_go    = ev(3'd0, 1,0,0,1,1,0,0,0,0,0,0, 2'b01, 3'd4, 0,0,0,0);
    dec_v   = ev(3'd1, 0,0,0,0,0,0,0,0,0,0,0, 2'b11, 3'd4, 0,0,0,0);
    dec_ill = ev(3'd1, 0,0,0,0,0,0,0,0,0,0,0, 2'b11, 3'd4, 0,1,0,0);
    wb_r    = ev(3'd4, 0,0,0,0,0,0,1,1,0,0,0, 2'b00, 3'd0, 1,0,0,0);
    wb_i    = ev(3'd4, 0,0,0,0,0,0,1,0,0,0,0, 2'b00, 3'd0, 1,0,0,0);
    ex_mi   = ev(3'd2, 0,0,0,0,0,0,0,0,0,1,0, 2'b10, 3'd2, 0,0,0,0);
    mem_lw  = ev(3'd3, 1,0,1,0,0,0,0,0,0,0,0, 2'b00, 3'd0, 0,0,0,0);
    wb_lw   = ev(3'd4, 0,0,0,0,0,0,1,0,1,0,0, 2'b00, 3'd0, 1,0,0,0);
    mem_sw  = ev(3'd3, 0,1,1,0,0,0,0,0,0,0,0, 2'b00, 3'd0, 1,0,0,0);
    br_tk   = ev(3'd2, 0,0,0,0,1,1,0,0,0,0,1, 2'b00, 3'd6, 1,0,0,0);
    br_nt   = ev(3'd2, 0,0,0,0,0,0,0,0,0,0,1, 2'b00, 3'd6, 1,0,0,0);
    berr_f  = ev(3'd0, 0,0,0,0,0,0,0,0,0,0,0, 2'b00, 3'd0, 0,0,1,0);
    berr_m  = ev(3'd3, 0,0,0,0,0,0,0,0,0,0,0, 2'b00, 3'd0, 0,0,1,0);

    rst = 1'b1; op = '0; funct = '0; equal = 0; sign = 0; ovf = 0; mem_ready = 0;
    @(posedge clk);
    #1;

    // reset holds all outputs low even with mem_ready asserted
    step(1, 6'h00, 6'h20, 0, 0, 0, 1, zero_v);
    step(1, 6'h00, 6'h20, 0, 0, 0, 1, zero_v);

    // add r3,r1,r2: done in cycle 4
    fetch_decode(6'h00, 6'h20);
    step(0, 6'h00, 6'h20, 0, 0, 0, 1, ex_r(3'd2));
    step(0, 6'h00, 6'h20, 0, 0, 0, 1, wb_r);

    // lw with mem_ready 3 cycles late in MEM: done in cycle 8
    fetch_decode(6'h23, 6'h00);
    step(0, 6'h23, 6'h00, 0, 0, 0, 0, ex_mi);
    for (int i = 0; i < 3; i++) step(0, 6'h23, 6'h00, 0, 0, 0, 0, mem_lw);
    step(0, 6'h23, 6'h00, 0, 0, 0, 1, mem_lw);
    step(0, 6'h23, 6'h00, 0, 0, 0, 1, wb_lw);

    // branches: beq equal=1 taken, bne equal=1 not taken, bgtz positive taken
    fetch_decode(6'h04, 6'h00);
    step(0, 6'h04, 6'h00, 1, 0, 0, 1, br_tk);
    fetch_decode(6'h05, 6'h00);
    step(0, 6'h05, 6'h00, 1, 0, 0, 1, br_nt);
    fetch_decode(6'h07, 6'h00);
    step(0, 6'h07, 6'h00, 0, 0, 0, 1, br_tk);
    fetch_decode(6'h07, 6'h00);
    step(0, 6'h07, 6'h00, 0, 1, 0, 1, br_nt);

    // sw with immediate mem_ready
    fetch_decode(6'h2b, 6'h00);
    step(0, 6'h2b, 6'h00, 0, 0, 0, 1, ex_mi);
    step(0, 6'h2b, 6'h00, 0, 0, 0, 1, mem_sw);

    // FETCH timeout: 4 waiting cycles then bus_err on the 5th, stays in FETCH
    for (int i = 0; i < 4; i++) step(0, 6'h00, 6'h20, 0, 0, 0, 0, f_wait);
    step(0, 6'h00, 6'h20, 0, 0, 0, 0, berr_f);

    // illegal opcode, then a normal sub
    step(0, 6'h3f, 6'h00, 0, 0, 0, 1, f_go);
    step(0, 6'h3f, 6'h00, 0, 0, 0, 1, dec_ill);
    fetch_decode(6'h00, 6'h22);
    step(0, 6'h00, 6'h22, 0, 0, 0, 1, ex_r(3'd6));
    step(0, 6'h00, 6'h22, 0, 0, 0, 1, wb_r);

    // illegal funct in R-type
    step(0, 6'h00, 6'h3f, 0, 0, 0, 1, f_go);
    step(0, 6'h00, 6'h3f, 0, 0, 0, 1, dec_ill);

    // sll and sltu ALU codes
    fetch_decode(6'h00, 6'h00);
    step(0, 6'h00, 6'h00, 0, 0, 0, 1, ex_r(3'd5));
    step(0, 6'h00, 6'h00, 0, 0, 0, 1, wb_r);
    fetch_decode(6'h00, 6'h2b);
    step(0, 6'h00, 6'h2b, 0, 0, 0, 1, ex_r(3'd7));
    step(0, 6'h00, 6'h2b, 0, 0, 0, 1, wb_r);

    // addi with ovf=1
    fetch_decode(6'h08, 6'h00);
`ifdef CPU_OVF_TRAP_EN
    step(0, 6'h08, 6'h00, 0, 0, 1, 1,
         ev(3'd2, 0,0,0,0,0,0,0,0,0,1,0, 2'b10, 3'd2, 0,0,0,1));
`else
    step(0, 6'h08, 6'h00, 0, 0, 1, 1, ex_mi);
    step(0, 6'h08, 6'h00, 0, 0, 1, 1, wb_i);
`endif

    // addu with ovf=1 never traps
    fetch_decode(6'h00, 6'h21);
    step(0, 6'h00, 6'h21, 0, 0, 1, 1, ex_r(3'd4));
    step(0, 6'h00, 6'h21, 0, 0, 1, 1, wb_r);

    // MEM timeout on lw, then recovery in FETCH
    fetch_decode(6'h23, 6'h00);
    step(0, 6'h23, 6'h00, 0, 0, 0, 0, ex_mi);
    for (int i = 0; i < 4; i++) step(0, 6'h23, 6'h00, 0, 0, 0, 0, mem_lw);
    step(0, 6'h23, 6'h00, 0, 0, 0, 0, berr_m);
    step(0, 6'h23, 6'h00, 0, 0, 0, 0, f_wait);

    // reset mid-MEM: outputs drop in the same cycle, then restart cleanly
    step(0, 6'h23, 6'h00, 0, 0, 0, 1, f_go);
    step(0, 6'h23, 6'h00, 0, 0, 0, 1, dec_v);
    step(0, 6'h23, 6'h00, 0, 0, 0, 0, ex_mi);
    step(0, 6'h23, 6'h00, 0, 0, 0, 0, mem_lw);
    step(1, 6'h23, 6'h00, 0, 0, 0, 1, zero_v);
    step(1, 6'h23, 6'h00, 0, 0, 0, 1, zero_v);
    fetch_decode(6'h00, 6'h25);
    step(0, 6'h00, 6'h25, 0, 0, 0, 1, ex_r(3'd1));
    step(0, 6'h00, 6'h25, 0, 0, 0, 1, wb_r);

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
